load_store_unit: RTL and testbench

//  Sits between the RV32I core's memory stage and the zero-delay byte-addressed RAM model.

---
 rtl/lsu_pkg.sv | 30 +++
 rtl/lsu_lane.sv | 32 +++
 rtl/load_store_unit.sv | 120 ++++++++++++
 tb/tb_load_store_unit.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states
// and request legality helpers.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} lsu_state_t;

   function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr);
      case (funct3)
         F3_H, F3_HU: is_misaligned = addr[0];
         F3_W:        is_misaligned = |addr;
         default:     is_misaligned = 1'b0;
      endcase
   endfunction

   // Unsigned variants only exist for loads.
   function automatic logic is_illegal(input logic [2:0] funct3, input logic write);
      case (funct3)
         F3_B, F3_H, F3_W: is_illegal = 1'b0;
         F3_BU, F3_HU:     is_illegal = write;
         default:          is_illegal = 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/lsu_lane.sv
// Byte lane logic: extracts and extends load data from a big-endian RAM word,
// and merges sub-word store data into the word read back for read-modify-write.
module lsu_lane
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3_i,
   input  logic [31:0] rdata_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] load_o,
   output logic [31:0] merge_o
);

   always_comb begin
      load_o  = '0;
      merge_o = wdata_i;
      case (funct3_i)
         F3_B: begin
            load_o  = {{24{rdata_i[31]}}, rdata_i[31:24]};
            merge_o = {wdata_i[7:0], rdata_i[23:0]};
         end
         F3_H: begin
            load_o  = {{16{rdata_i[31]}}, rdata_i[31:16]};
            merge_o = {wdata_i[15:0], rdata_i[15:0]};
         end
         F3_W:    load_o = rdata_i;
         F3_BU:   load_o = {24'h0, rdata_i[31:24]};
         F3_HU:   load_o = {16'h0, rdata_i[31:16]};
         default: load_o = '0;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the core memory stage and a zero-delay big-endian RAM.
// Sub-word stores are done as read (ACCESS) then merged write (WRITE).
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int unsigned dataW       = 32,
   parameter int unsigned RAMAddrSize = 32,
   parameter bit          CheckAlign  = 1'b0
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   ReqValid,
   output logic                   ReqReady,
   input  logic [2:0]             ReqFunct3,
   input  logic                   ReqWrite,
   input  logic [RAMAddrSize-1:0] ReqAddr,
   input  logic [dataW-1:0]       ReqWData,
   output logic                   RespValid,
   input  logic                   RespReady,
   output logic [dataW-1:0]       RespRData,
   output logic                   RespErr,
   output logic [RAMAddrSize-1:0] RAMAddr,
   output logic [dataW-1:0]       DataIn,
   output logic                   RAMWriteControl,
   input  logic [dataW-1:0]       RAMOut
);

   lsu_state_t             state_q;
   logic [2:0]             f3_q;
   logic                   write_q;
   logic [dataW-1:0]       wdata_q;
   logic                   ready_q, valid_q, err_q, wr_q;
   logic [dataW-1:0]       rdata_q, datain_q;
   logic [RAMAddrSize-1:0] ramaddr_q;
   logic [dataW-1:0]       load_d, merge_d;

   lsu_lane u_lane (
      .funct3_i (f3_q),
      .rdata_i  (RAMOut),
      .wdata_i  (wdata_q),
      .load_o   (load_d),
      .merge_o  (merge_d)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         f3_q      <= '0;
         write_q   <= 1'b0;
         wdata_q   <= '0;
         ready_q   <= 1'b1;
         valid_q   <= 1'b0;
         err_q     <= 1'b0;
         wr_q      <= 1'b0;
         rdata_q   <= '0;
         datain_q  <= '0;
         ramaddr_q <= '0;
      end else begin
         case (state_q)
            IDLE: if (ReqValid && ready_q) begin
               f3_q    <= ReqFunct3;
               write_q <= ReqWrite;
               wdata_q <= ReqWData;
               ready_q <= 1'b0;
               rdata_q <= '0;
               err_q   <= 1'b0;
               if (is_illegal(ReqFunct3, ReqWrite) ||
                   (CheckAlign && is_misaligned(ReqFunct3, ReqAddr[1:0]))) begin
                  err_q   <= 1'b1;
                  valid_q <= 1'b1;
                  state_q <= RESP;
               end else begin
                  ramaddr_q <= ReqAddr;
                  state_q   <= ACCESS;
                  // Full-word stores pulse the strobe during ACCESS itself.
                  if (ReqWrite && ReqFunct3 == F3_W) begin
                     datain_q <= ReqWData;
                     wr_q     <= 1'b1;
                  end
               end
            end
            ACCESS: begin
               if (!write_q) begin
                  rdata_q <= load_d;
                  valid_q <= 1'b1;
                  state_q <= RESP;
               end else if (f3_q == F3_W) begin
                  wr_q    <= 1'b0;
                  valid_q <= 1'b1;
                  state_q <= RESP;
               end else begin
                  datain_q <= merge_d;
                  wr_q     <= 1'b1;
                  state_q  <= WRITE;
               end
            end
            WRITE: begin
               wr_q    <= 1'b0;
               valid_q <= 1'b1;
               state_q <= RESP;
            end
            RESP: if (RespReady) begin
               valid_q <= 1'b0;
               ready_q <= 1'b1;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign ReqReady        = ready_q;
   assign RespValid       = valid_q;
   assign RespRData       = rdata_q;
   assign RespErr         = err_q;
   assign RAMAddr         = ramaddr_q;
   assign DataIn          = datain_q;
   assign RAMWriteControl = wr_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: byte-array reference model, randomized
// and directed requests, plus a CheckAlign=1 instance for alignment errors.
module tb_load_store_unit;
   import lsu_pkg::*;

   typedef struct {
      logic [31:0] data;
      logic        err;
      int unsigned lat;
      int unsigned acc;
      int unsigned pulses;
      string       nm;
   } exp_t;

   logic        clock = 1'b0;
   logic        reset;
   logic        ReqValid, ReqReady, ReqWrite, RespValid, RespReady, RespErr, RAMWriteControl;
   logic [2:0]  ReqFunct3;
   logic [31:0] ReqAddr, ReqWData, RespRData, RAMAddr, DataIn, RAMOut;
   logic        ReqValid2, ReqReady2, ReqWrite2, RespValid2, RespReady2, RespErr2, RAMWriteControl2;
   logic [2:0]  ReqFunct32;
   logic [31:0] ReqAddr2, ReqWData2, RespRData2, RAMAddr2, DataIn2, RAMOut2;

   logic [7:0]  mem  [0:511];
   logic [7:0]  mem2 [0:511];
   logic [7:0]  refm [0:511];
   exp_t        sbq[$];
   int unsigned cyc = 0;
   int unsigned checks = 0;
   int unsigned errors = 0;
   int unsigned rr_mode = 1;
   exp_t        mon_e;
   int unsigned mon_p = 0;
   bit          mon_got = 1'b0;

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   load_store_unit #(.dataW(32), .RAMAddrSize(32), .CheckAlign(1'b0)) dut (
      .clock(clock), .reset(reset), .ReqValid(ReqValid), .ReqReady(ReqReady),
      .ReqFunct3(ReqFunct3), .ReqWrite(ReqWrite), .ReqAddr(ReqAddr), .ReqWData(ReqWData),
      .RespValid(RespValid), .RespReady(RespReady), .RespRData(RespRData), .RespErr(RespErr),
      .RAMAddr(RAMAddr), .DataIn(DataIn), .RAMWriteControl(RAMWriteControl), .RAMOut(RAMOut)
   );

   load_store_unit #(.dataW(32), .RAMAddrSize(32), .CheckAlign(1'b1)) dut2 (
      .clock(clock), .reset(reset), .ReqValid(ReqValid2), .ReqReady(ReqReady2),
      .ReqFunct3(ReqFunct32), .ReqWrite(ReqWrite2), .ReqAddr(ReqAddr2), .ReqWData(ReqWData2),
      .RespValid(RespValid2), .RespReady(RespReady2), .RespRData(RespRData2), .RespErr(RespErr2),
      .RAMAddr(RAMAddr2), .DataIn(DataIn2), .RAMWriteControl(RAMWriteControl2), .RAMOut(RAMOut2)
   );

   // Zero-delay big-endian RAM models, 512 bytes, addresses wrap.
   logic [8:0] a0, b0;
   assign a0 = RAMAddr[8:0];
   assign b0 = RAMAddr2[8:0];
   assign RAMOut  = {mem[a0],  mem[a0 + 9'd1],  mem[a0 + 9'd2],  mem[a0 + 9'd3]};
   assign RAMOut2 = {mem2[b0], mem2[b0 + 9'd1], mem2[b0 + 9'd2], mem2[b0 + 9'd3]};
   always @(posedge clock) begin
      if (RAMWriteControl) begin
         mem[a0] <= DataIn[31:24]; mem[a0 + 9'd1] <= DataIn[23:16];
         mem[a0 + 9'd2] <= DataIn[15:8]; mem[a0 + 9'd3] <= DataIn[7:0];
      end
      if (RAMWriteControl2) begin
         mem2[b0] <= DataIn2[31:24]; mem2[b0 + 9'd1] <= DataIn2[23:16];
         mem2[b0 + 9'd2] <= DataIn2[15:8]; mem2[b0 + 9'd3] <= DataIn2[7:0];
      end
   end

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, req);
      end
   endfunction

   // Reference model: byte array semantics straight from the ISA rules.
   function automatic void model(input logic [2:0] f3, input logic wr, input logic [31:0] addr,
                                 input logic [31:0] wd, output exp_t e);
      logic [8:0]  a;
      int unsigned b, h;
      bit          legal;
      a = addr[8:0];
      legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5) &&
              !(wr && f3 >= 3'd4);
      e.data = 32'd0; e.err = 1'b0; e.pulses = 0; e.lat = 2;
      if (!legal) begin
         e.err = 1'b1; e.lat = 1;
      end else if (!wr) begin
         b = refm[a];
         h = refm[a] * 256 + refm[a + 9'd1];
         case (f3)
            3'd0:    e.data = (b >= 128) ? b - 256 : b;
            3'd1:    e.data = (h >= 32768) ? h - 65536 : h;
            3'd4:    e.data = b;
            3'd5:    e.data = h;
            default: e.data = {refm[a], refm[a + 9'd1], refm[a + 9'd2], refm[a + 9'd3]};
         endcase
      end else begin
         e.pulses = 1;
         case (f3)
            3'd0: begin refm[a] = wd[7:0]; e.lat = 3; end
            3'd1: begin refm[a] = wd[15:8]; refm[a + 9'd1] = wd[7:0]; e.lat = 3; end
            default: begin
               refm[a] = wd[31:24]; refm[a + 9'd1] = wd[23:16];
               refm[a + 9'd2] = wd[15:8]; refm[a + 9'd3] = wd[7:0];
            end
         endcase
      end
   endfunction

   task automatic issue(input logic [2:0] f3, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wd, input bit use_exp, input logic [31:0] exp_d,
                        input string nm, output int unsigned acc);
      exp_t        e;
      int unsigned n = 0;
      @(negedge clock);
      ReqValid = 1'b1; ReqFunct3 = f3; ReqWrite = wr; ReqAddr = addr; ReqWData = wd;
      while (!ReqReady && n < 50) begin @(negedge clock); n++; end
      if (!ReqReady) begin
         chk({nm, " req_timeout"}, 32'(ReqReady), 32'd1);
         ReqValid = 1'b0; acc = 0;
         return;
      end
      acc = cyc;
      model(f3, wr, addr, wd, e);
      if (use_exp) e.data = exp_d;
      e.acc = acc;
      e.nm  = $sformatf("%s@%0h", nm, addr);
      sbq.push_back(e);
      @(posedge clock); #1;
      ReqValid = 1'b0;
   endtask

   task automatic drain();
      int unsigned n = 0;
      rr_mode = 1;
      while (sbq.size() != 0 && n < 200) begin @(negedge clock); n++; end
      chk("drain", 32'(sbq.size()), 32'd0);
      @(negedge clock);
   endtask

   task automatic req2(input logic [2:0] f3, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] ed, input logic ee,
                       input int unsigned el, input int unsigned ep, input string nm);
      int unsigned acc, n = 0, p = 0;
      @(negedge clock);
      chk({nm, " ready"}, 32'(ReqReady2), 32'd1);
      ReqValid2 = 1'b1; ReqFunct32 = f3; ReqWrite2 = wr; ReqAddr2 = addr; ReqWData2 = wd;
      acc = cyc;
      @(posedge clock); #1;
      ReqValid2 = 1'b0;
      do begin
         @(negedge clock);
         if (RAMWriteControl2) p++;
         n++;
      end while (!RespValid2 && n < 20);
      chk({nm, " valid"}, 32'(RespValid2), 32'd1);
      chk({nm, " data"}, RespRData2, ed);
      chk({nm, " err"}, 32'(RespErr2), 32'(ee));
      chk({nm, " latency"}, cyc - acc, el);
      chk({nm, " wr_pulses"}, p, ep);
   endtask

   task automatic set_pattern();
      mem[9'h100] = 8'h80; mem[9'h101] = 8'h12; mem[9'h102] = 8'h34; mem[9'h103] = 8'h56;
      refm[9'h100] = 8'h80; refm[9'h101] = 8'h12; refm[9'h102] = 8'h34; refm[9'h103] = 8'h56;
   endtask

   // Response monitor: pops the scoreboard on the first cycle of each response.
   always @(negedge clock) begin
      if (!reset) begin
         mon_p = 0; mon_got = 1'b0;
      end else begin
         if (RAMWriteControl) mon_p++;
         if (!RespValid) mon_got = 1'b0;
         else if (!mon_got) begin
            mon_got = 1'b1;
            if (sbq.size() == 0) chk("resp_unexpected", 32'(RespValid), 32'd0);
            else begin
               mon_e = sbq.pop_front();
               chk({mon_e.nm, " data"}, RespRData, mon_e.data);
               chk({mon_e.nm, " err"}, 32'(RespErr), 32'(mon_e.err));
               chk({mon_e.nm, " latency"}, cyc - mon_e.acc, mon_e.lat);
               chk({mon_e.nm, " wr_pulses"}, mon_p, mon_e.pulses);
            end
            mon_p = 0;
         end
      end
   end

   initial begin
      RespReady = 1'b0;
      forever begin
         @(posedge clock); #2;
         case (rr_mode)
            0:       RespReady = 1'b0;
            1:       RespReady = 1'b1;
            default: RespReady = ($urandom_range(0, 1) == 1);
         endcase
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned acc, r;
      logic [7:0]  b4, b5;
      logic [2:0]  f3;
      logic        wr;
      reset = 1'b0; ReqValid = 1'b0; ReqFunct3 = '0; ReqWrite = 1'b0; ReqAddr = '0; ReqWData = '0;
      ReqValid2 = 1'b0; ReqFunct32 = '0; ReqWrite2 = 1'b0; ReqAddr2 = '0; ReqWData2 = '0;
      RespReady2 = 1'b1;
      for (int i = 0; i < 512; i++) begin
         mem[i] = 8'($urandom); refm[i] = mem[i]; mem2[i] = 8'(i);
      end
      set_pattern();
      repeat (3) @(negedge clock);
      chk("rst ReqReady", 32'(ReqReady), 32'd1);
      chk("rst RespValid", 32'(RespValid), 32'd0);
      chk("rst RespRData", RespRData, 32'd0);
      chk("rst RespErr", 32'(RespErr), 32'd0);
      chk("rst RAMWriteControl", 32'(RAMWriteControl), 32'd0);
      chk("rst RAMAddr", RAMAddr, 32'd0);
      chk("rst DataIn", DataIn, 32'd0);
      reset = 1'b1;

      issue(F3_B,  1'b0, 32'h100, 32'd0, 1, 32'hFFFFFF80, "LB",  acc);
      issue(F3_BU, 1'b0, 32'h100, 32'd0, 1, 32'h00000080, "LBU", acc);
      issue(F3_H,  1'b0, 32'h100, 32'd0, 1, 32'hFFFF8012, "LH",  acc);
      issue(F3_W,  1'b0, 32'h100, 32'd0, 1, 32'h80123456, "LW",  acc);
      issue(F3_W,  1'b0, 32'h101, 32'd0, 1, {24'h123456, refm[9'h104]}, "LW_mis", acc);
      drain();

      // Reset while an SB sits in ACCESS: the merged write must never happen.
      ReqValid = 1'b1; ReqFunct3 = F3_B; ReqWrite = 1'b1; ReqAddr = 32'h100; ReqWData = 32'hAB;
      chk("rmw_rst pre_ready", 32'(ReqReady), 32'd1);
      @(posedge clock); #1;
      ReqValid = 1'b0;
      reset = 1'b0;
      repeat (2) @(negedge clock);
      chk("rmw_rst RespValid", 32'(RespValid), 32'd0);
      chk("rmw_rst ReqReady", 32'(ReqReady), 32'd1);
      chk("rmw_rst wr", 32'(RAMWriteControl), 32'd0);
      reset = 1'b1;
      repeat (2) @(negedge clock);
      chk("rmw_rst mem", {mem[9'h100], mem[9'h101], mem[9'h102], mem[9'h103]}, 32'h80123456);
      issue(F3_W, 1'b0, 32'h100, 32'd0, 1, 32'h80123456, "LW_after_rst", acc);

      issue(F3_B, 1'b1, 32'h100, 32'h000000AB, 0, 32'd0, "SB", acc);
      issue(F3_W, 1'b0, 32'h100, 32'd0, 1, 32'hAB123456, "LW_after_SB", acc);
      drain();

      set_pattern();
      b4 = mem[9'h104]; b5 = mem[9'h105];
      issue(F3_H, 1'b1, 32'h102, 32'h0000CAFE, 0, 32'd0, "SH", acc);
      issue(F3_W, 1'b0, 32'h100, 32'd0, 1, 32'h8012CAFE, "LW_after_SH", acc);
      drain();
      chk("SH mem104", 32'(mem[9'h104]), 32'(b4));
      chk("SH mem105", 32'(mem[9'h105]), 32'(b5));

      // Response held off for 5 cycles, then the next request follows immediately.
      rr_mode = 0;
      @(negedge clock);
      issue(F3_W, 1'b0, 32'h100, 32'd0, 1, 32'h8012CAFE, "LW_hold", acc);
      for (int n = 0; n < 20 && !RespValid; n++) @(negedge clock);
      chk("hold seen", 32'(RespValid), 32'd1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         chk("hold RespValid", 32'(RespValid), 32'd1);
         chk("hold RespRData", RespRData, 32'h8012CAFE);
         chk("hold ReqReady", 32'(ReqReady), 32'd0);
      end
      rr_mode = 1;
      @(posedge clock); #3;
      r = cyc;
      issue(F3_HU, 1'b0, 32'h102, 32'd0, 1, 32'h0000CAFE, "LHU_next", acc);
      chk("accept_after_ready", acc, r + 1);
      drain();

      req2(F3_W,  1'b0, 32'h101, 32'd0,       32'd0,        1'b1, 1, 0, "CA LW_mis");
      req2(F3_W,  1'b1, 32'h102, 32'hDEADBEEF, 32'd0,       1'b1, 1, 0, "CA SW_mis");
      chk("CA SW_mis mem", {mem2[9'h102], mem2[9'h103], mem2[9'h104], mem2[9'h105]}, 32'h02030405);
      req2(F3_H,  1'b0, 32'h102, 32'd0,       32'h00000203, 1'b0, 2, 0, "CA LH");
      req2(F3_HU, 1'b0, 32'h103, 32'd0,       32'd0,        1'b1, 1, 0, "CA LHU_mis");
      req2(F3_B,  1'b0, 32'h103, 32'd0,       32'h00000003, 1'b0, 2, 0, "CA LB");
      req2(F3_B,  1'b1, 32'h101, 32'h000000FF, 32'd0,       1'b0, 3, 1, "CA SB");
      req2(F3_B,  1'b0, 32'h101, 32'd0,       32'hFFFFFFFF, 1'b0, 2, 0, "CA LB_after_SB");
      req2(F3_H,  1'b1, 32'h104, 32'h00001234, 32'd0,       1'b0, 3, 1, "CA SH");
      req2(F3_HU, 1'b0, 32'h104, 32'd0,       32'h00001234, 1'b0, 2, 0, "CA LHU");
      req2(3'b011, 1'b0, 32'h100, 32'd0,      32'd0,        1'b1, 1, 0, "CA illegal");

      rr_mode = 2;
      for (int i = 0; i < 300; i++) begin
         case ($urandom_range(0, 9))
            0: begin f3 = F3_B;  wr = 1'b0; end
            1: begin f3 = F3_H;  wr = 1'b0; end
            2: begin f3 = F3_W;  wr = 1'b0; end
            3: begin f3 = F3_BU; wr = 1'b0; end
            4: begin f3 = F3_HU; wr = 1'b0; end
            5: begin f3 = F3_B;  wr = 1'b1; end
            6: begin f3 = F3_H;  wr = 1'b1; end
            7: begin f3 = F3_W;  wr = 1'b1; end
            8: begin f3 = ($urandom_range(0, 2) == 0) ? 3'b011 : 3'(6 + $urandom_range(0, 1)); wr = 1'b0; end
            default: begin f3 = 3'(4 + $urandom_range(0, 1)); wr = 1'b1; end
         endcase
         issue(f3, wr, 32'($urandom_range(0, 511)), $urandom, 0, 32'd0, "rnd", acc);
      end
      drain();
      for (int i = 0; i < 512; i++) chk($sformatf("final mem[%0h]", i), 32'(mem[i]), 32'(refm[i]));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
